// File: rtl/control_unit_mc_pkg.sv
// rtl/control_unit_mc_pkg.sv - shared opcodes, states, bus/ALU codes and write-enable positions
package control_unit_mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_FETCH1, S_FETCH2, S_FETCH3,
        S_EXEC1, S_EXEC2, S_EXEC3, S_EXEC4
    } state_t;

    localparam int OP_NOP   = 0;
    localparam int OP_LDACI = 1;
    localparam int OP_LDAC  = 2;
    localparam int OP_STACI = 3;
    localparam int OP_STAC  = 4;
    localparam int OP_LDAR  = 5;
    localparam int OP_MVAC  = 6;
    localparam int OP_MVR   = 7;
    localparam int OP_ADD   = 8;
    localparam int OP_SUB   = 9;
    localparam int OP_MUL   = 10;
    localparam int OP_ADDTR = 11;
    localparam int OP_INCAC = 12;
    localparam int OP_CLRAC = 13;
    localparam int OP_CLRTR = 14;
    localparam int OP_JPNZ  = 15;
    localparam int OP_JPZ   = 16;
    localparam int OP_ENDOP = 17;

    localparam int BUS_IMEM = 0;
    localparam int BUS_DMEM = 1;
    localparam int BUS_PC   = 2;
    localparam int BUS_DR   = 3;
    localparam int BUS_AC   = 5;
    localparam int BUS_TR   = 6;
    localparam int BUS_R0   = 7;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_MUL  = 4'd2;
    localparam logic [3:0] ALU_PASS = 4'd5;

    // General registers occupy the low NUM_GPR enable bits; fixed registers sit above them.
    function automatic int we_ac(input int n);  return n;     endfunction
    function automatic int we_tr(input int n);  return n + 1; endfunction
    function automatic int we_ir(input int n);  return n + 2; endfunction
    function automatic int we_dr(input int n);  return n + 3; endfunction
    function automatic int we_pc(input int n);  return n + 4; endfunction
    function automatic int we_ar(input int n);  return n + 5; endfunction
    function automatic int we_arb(input int n); return n + 6; endfunction

endpackage

// File: rtl/control_unit_mc_dec.sv
// rtl/control_unit_mc_dec.sv - combinational next-state and control-word decoder
module control_unit_mc_dec
    import control_unit_mc_pkg::*;
#(
    parameter int IR_W    = 8,
    parameter int IDX_W   = 3,
    parameter int NUM_GPR = 5,
    localparam int BUS_W  = $clog2(7 + NUM_GPR),
    localparam int WE_W   = 7 + NUM_GPR
) (
    input  state_t             state,
    input  logic               start,
    input  logic [IR_W-1:0]    ir,
    input  logic               z,
    output state_t             nxt,
    output logic               mem_step,
    output logic [WE_W-1:0]    write_en,
    output logic [BUS_W-1:0]   bus_ld,
    output logic [3:0]         alu_mode,
    output logic [1:0]         inc,
    output logic [2:0]         clr,
    output logic               dm_wr,
    output logic               end_op,
    output logic               illegal_op
);

    localparam int OPC_W = IR_W - IDX_W;

    logic [OPC_W-1:0] opc;
    logic [IDX_W-1:0] idx;
    logic [BUS_W-1:0] reg_bus;
    logic             reg_ok;
    logic             jmp_taken;
    int               op;

    assign opc       = ir[IR_W-1:IDX_W];
    assign idx       = ir[IDX_W-1:0];
    assign op        = int'(opc);
    assign reg_ok    = int'(idx) < NUM_GPR;
    assign jmp_taken = (op == OP_JPZ) ? z : ~z;
    assign reg_bus   = BUS_W'(BUS_R0 + int'(idx));

    function automatic logic [WE_W-1:0] we1(input int pos);
        return WE_W'(1) << pos;
    endfunction

    always_comb begin
        nxt        = state;
        mem_step   = 1'b0;
        write_en   = '0;
        bus_ld     = '0;
        alu_mode   = ALU_ADD;
        inc        = 2'b00;
        clr        = 3'b000;
        dm_wr      = 1'b0;
        end_op     = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_IDLE:   if (start) nxt = S_INIT;
            S_INIT:   begin clr = 3'b111; nxt = S_FETCH1; end
            S_FETCH1: begin write_en = we1(we_ar(NUM_GPR)); bus_ld = BUS_W'(BUS_PC); nxt = S_FETCH2; end
            S_FETCH2: begin
                mem_step = 1'b1;
                write_en = we1(we_dr(NUM_GPR));
                inc      = 2'b01;
                nxt      = S_FETCH3;
            end
            S_FETCH3: begin write_en = we1(we_ir(NUM_GPR)); bus_ld = BUS_W'(BUS_DR); nxt = S_EXEC1; end
            S_EXEC1: begin
                nxt = S_FETCH1;
                // Undefined opcodes and out-of-range register indices behave as NOP.
                if (op > OP_ENDOP || (op >= OP_LDAR && op <= OP_MUL && !reg_ok)) begin
                    illegal_op = 1'b1;
                end else begin
                    case (op)
                        OP_LDACI, OP_STACI: begin
                            mem_step = 1'b1;
                            write_en = we1(we_dr(NUM_GPR));
                            nxt      = S_EXEC2;
                        end
                        OP_LDAC: begin
                            mem_step = 1'b1;
                            bus_ld   = BUS_W'(BUS_DMEM);
                            write_en = we1(we_dr(NUM_GPR));
                            nxt      = S_EXEC2;
                        end
                        OP_STAC: begin mem_step = 1'b1; bus_ld = BUS_W'(BUS_AC); dm_wr = 1'b1; end
                        OP_LDAR: begin
                            bus_ld   = reg_bus;
                            write_en = we1(we_arb(NUM_GPR)) | we1(we_ar(NUM_GPR));
                        end
                        OP_MVAC: begin bus_ld = BUS_W'(BUS_AC); write_en = we1(int'(idx)); end
                        OP_MVR:  begin bus_ld = reg_bus; write_en = we1(we_ac(NUM_GPR)); alu_mode = ALU_PASS; end
                        OP_ADD, OP_SUB, OP_MUL: begin
                            bus_ld   = reg_bus;
                            write_en = we1(we_ac(NUM_GPR));
                            alu_mode = (op == OP_ADD) ? ALU_ADD : (op == OP_SUB) ? ALU_SUB : ALU_MUL;
                        end
                        OP_ADDTR: begin bus_ld = BUS_W'(BUS_TR); write_en = we1(we_ac(NUM_GPR)); nxt = S_EXEC2; end
                        OP_INCAC: inc = 2'b10;
                        OP_CLRAC: clr = 3'b100;
                        OP_CLRTR: clr = 3'b010;
                        OP_JPNZ, OP_JPZ: begin
                            if (jmp_taken) begin
                                mem_step = 1'b1;
                                write_en = we1(we_dr(NUM_GPR));
                                nxt      = S_EXEC2;
                            end else begin
                                inc = 2'b01;
                            end
                        end
                        OP_ENDOP: begin end_op = 1'b1; nxt = S_IDLE; end
                        default: ;
                    endcase
                end
            end
            S_EXEC2: begin
                nxt = S_FETCH1;
                case (op)
                    OP_LDACI, OP_STACI: begin
                        bus_ld   = BUS_W'(BUS_DR);
                        write_en = we1(we_arb(NUM_GPR)) | we1(we_ar(NUM_GPR));
                        inc      = 2'b01;
                        nxt      = S_EXEC3;
                    end
                    OP_LDAC:  begin bus_ld = BUS_W'(BUS_DR); write_en = we1(we_ac(NUM_GPR)); alu_mode = ALU_PASS; end
                    OP_ADDTR: begin bus_ld = BUS_W'(BUS_AC); write_en = we1(we_tr(NUM_GPR)); end
                    // Only a taken jump reaches EXEC2.
                    OP_JPNZ, OP_JPZ: begin bus_ld = BUS_W'(BUS_DR); write_en = we1(we_pc(NUM_GPR)); end
                    default: ;
                endcase
            end
            S_EXEC3: begin
                nxt      = S_FETCH1;
                mem_step = 1'b1;
                if (op == OP_LDACI) begin
                    bus_ld   = BUS_W'(BUS_DMEM);
                    write_en = we1(we_dr(NUM_GPR));
                    nxt      = S_EXEC4;
                end else begin
                    bus_ld = BUS_W'(BUS_AC);
                    dm_wr  = 1'b1;
                end
            end
            S_EXEC4: begin
                nxt      = S_FETCH1;
                bus_ld   = BUS_W'(BUS_DR);
                write_en = we1(we_ac(NUM_GPR));
                alu_mode = ALU_PASS;
            end
            default: nxt = S_IDLE;
        endcase
    end

endmodule

// File: rtl/control_unit_mc.sv
// rtl/control_unit_mc.sv - multi-cycle control unit: state register and memory-stall gating
module control_unit_mc
    import control_unit_mc_pkg::*;
#(
    parameter int IR_W    = 8,
    parameter int IDX_W   = 3,
    parameter int NUM_GPR = 5,
    parameter int MEM_HS  = 1,
    localparam int BUS_W  = $clog2(7 + NUM_GPR),
    localparam int WE_W   = 7 + NUM_GPR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IR_W-1:0]  ir,
    input  logic             z,
    input  logic             mem_rdy,
    output logic             busy,
    output logic             end_op,
    output logic             illegal_op,
    output logic             mem_req,
    output logic [1:0]       inc,
    output logic [3:0]       alu_mode,
    output logic [BUS_W-1:0] bus_ld,
    output logic [WE_W-1:0]  write_en,
    output logic [2:0]       clr,
    output logic             dm_wr,
    output logic             im_wr
);

    state_t             state, nxt;
    logic               step_mem, rdy, stall;
    logic [WE_W-1:0]    d_we;
    logic [1:0]         d_inc;
    logic               d_dm;

    control_unit_mc_dec #(.IR_W(IR_W), .IDX_W(IDX_W), .NUM_GPR(NUM_GPR)) u_dec (
        .state      (state),
        .start      (start),
        .ir         (ir),
        .z          (z),
        .nxt        (nxt),
        .mem_step   (step_mem),
        .write_en   (d_we),
        .bus_ld     (bus_ld),
        .alu_mode   (alu_mode),
        .inc        (d_inc),
        .clr        (clr),
        .dm_wr      (d_dm),
        .end_op     (end_op),
        .illegal_op (illegal_op)
    );

    assign rdy   = (MEM_HS != 0) ? mem_rdy : 1'b1;
    assign stall = step_mem & ~rdy;

    // The word is decoded from the state register so EXEC steps see the IR loaded in FETCH3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      state <= S_IDLE;
        else if (!stall) state <= nxt;
    end

    assign busy     = (state != S_IDLE);
    assign mem_req  = step_mem;
    assign write_en = stall ? '0 : d_we;
    assign inc      = stall ? 2'b00 : d_inc;
    assign dm_wr    = d_dm & ~stall;
    assign im_wr    = 1'b0;

endmodule

// File: tb/tb_control_unit_mc.sv
// tb/tb_control_unit_mc.sv - scoreboard bench for control_unit_mc with random programs
module tb_control_unit_mc;

    localparam logic [11:0] M_AC  = 12'h020, M_TR = 12'h040, M_IR = 12'h080, M_DR = 12'h100;
    localparam logic [11:0] M_PC  = 12'h200, M_AR = 12'h400, M_ARB = 12'h800;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, z = 1'b0, mem_rdy = 1'b1;
    logic [7:0]  ir = 8'h00;
    logic        busy, end_op, illegal_op, mem_req, dm_wr, im_wr;
    logic [1:0]  inc;
    logic [3:0]  alu_mode, bus_ld;
    logic [11:0] write_en;
    logic [2:0]  clr;

    control_unit_mc dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .z(z), .mem_rdy(mem_rdy),
        .busy(busy), .end_op(end_op), .illegal_op(illegal_op), .mem_req(mem_req),
        .inc(inc), .alu_mode(alu_mode), .bus_ld(bus_ld), .write_en(write_en),
        .clr(clr), .dm_wr(dm_wr), .im_wr(im_wr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mem;
        logic [1:0]  inc;
        logic [3:0]  alu;
        logic [3:0]  bus;
        logic [11:0] we;
        logic [2:0]  clr;
        logic        dm;
        logic        eop;
        logic        ill;
    } step_t;

    typedef struct { int op; int idx; bit zz; int want; } instr_t;

    step_t  expq[$];
    instr_t prog[$];
    int checks = 0, failures = 0;
    int want = 0, rdy_cnt = 0, run = 0;

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, a, e, $time);
        end
    endtask

    function automatic step_t st(input bit mem, input logic [11:0] we, input int bus, input int inc_v,
                                 input int alu, input int clr_v, input bit dm, input bit eop, input bit ill);
        step_t s;
        s.mem = mem; s.we = we; s.bus = 4'(bus); s.inc = 2'(inc_v); s.alu = 4'(alu);
        s.clr = 3'(clr_v); s.dm = dm; s.eop = eop; s.ill = ill;
        return s;
    endfunction

    function automatic step_t observed();
        return {mem_req, inc, alu_mode, bus_ld, write_en, clr, dm_wr, end_op, illegal_op};
    endfunction

    // Reference: list of accepted steps per instruction, straight from the micro-op table.
    task automatic push_instr(input instr_t in);
        int  rn_bus = 7 + in.idx;
        bit  reg_op = (in.op >= 5 && in.op <= 10);
        bit  taken  = (in.op == 16) ? in.zz : !in.zz;
        expq.push_back(st(0, M_AR, 2, 0, 0, 0, 0, 0, 0));
        expq.push_back(st(1, M_DR, 0, 1, 0, 0, 0, 0, 0));
        expq.push_back(st(0, M_IR, 3, 0, 0, 0, 0, 0, 0));
        if (in.op > 17 || (reg_op && in.idx >= 5)) begin
            expq.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 1));
            return;
        end
        case (in.op)
            1: begin
                expq.push_back(st(1, M_DR, 0, 0, 0, 0, 0, 0, 0));
                expq.push_back(st(0, M_ARB | M_AR, 3, 1, 0, 0, 0, 0, 0));
                expq.push_back(st(1, M_DR, 1, 0, 0, 0, 0, 0, 0));
                expq.push_back(st(0, M_AC, 3, 0, 5, 0, 0, 0, 0));
            end
            2: begin
                expq.push_back(st(1, M_DR, 1, 0, 0, 0, 0, 0, 0));
                expq.push_back(st(0, M_AC, 3, 0, 5, 0, 0, 0, 0));
            end
            3: begin
                expq.push_back(st(1, M_DR, 0, 0, 0, 0, 0, 0, 0));
                expq.push_back(st(0, M_ARB | M_AR, 3, 1, 0, 0, 0, 0, 0));
                expq.push_back(st(1, 0, 5, 0, 0, 0, 1, 0, 0));
            end
            4:  expq.push_back(st(1, 0, 5, 0, 0, 0, 1, 0, 0));
            5:  expq.push_back(st(0, M_ARB | M_AR, rn_bus, 0, 0, 0, 0, 0, 0));
            6:  expq.push_back(st(0, 12'(1) << in.idx, 5, 0, 0, 0, 0, 0, 0));
            7:  expq.push_back(st(0, M_AC, rn_bus, 0, 5, 0, 0, 0, 0));
            8, 9, 10: expq.push_back(st(0, M_AC, rn_bus, 0, in.op - 8, 0, 0, 0, 0));
            11: begin
                expq.push_back(st(0, M_AC, 6, 0, 0, 0, 0, 0, 0));
                expq.push_back(st(0, M_TR, 5, 0, 0, 0, 0, 0, 0));
            end
            12: expq.push_back(st(0, 0, 0, 2, 0, 0, 0, 0, 0));
            13: expq.push_back(st(0, 0, 0, 0, 0, 4, 0, 0, 0));
            14: expq.push_back(st(0, 0, 0, 0, 0, 2, 0, 0, 0));
            15, 16: begin
                if (taken) begin
                    expq.push_back(st(1, M_DR, 0, 0, 0, 0, 0, 0, 0));
                    expq.push_back(st(0, M_PC, 3, 0, 0, 0, 0, 0, 0));
                end else begin
                    expq.push_back(st(0, 0, 0, 1, 0, 0, 0, 0, 0));
                end
            end
            17: expq.push_back(st(0, 0, 0, 0, 0, 0, 0, 1, 0));
            default: expq.push_back(st(0, 0, 0, 0, 0, 0, 0, 0, 0));
        endcase
    endtask

    // Memory side: hold mem_rdy low for `want` cycles at the start of each memory step.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                if (rdy_cnt < want) begin mem_rdy = 1'b0; rdy_cnt++; end
                else begin mem_rdy = 1'b1; rdy_cnt = 0; end
            end else begin
                mem_rdy = 1'($urandom_range(0, 1));
                rdy_cnt = 0;
            end
        end
    end

    // Monitor: compares every presented step against the scoreboard.
    always @(negedge clk) begin
        step_t act, exp;
        if (rst_n) begin
            act = observed();
            if (!busy) begin
                if (act != '0) chk("idle_word", act, 0);
            end else if (expq.size() == 0) begin
                chk("unexpected_step", act, 0);
            end else if (mem_req && !mem_rdy) begin
                run++;
                exp = expq[0];
                exp.we = '0; exp.inc = '0; exp.dm = 1'b0;
                chk("stall_word", act, exp);
            end else begin
                if (mem_req) begin
                    run++;
                    chk("mem_req_len", run, want + 1);
                    run = 0;
                end
                exp = expq.pop_front();
                chk("step_word", act, exp);
            end
        end
    end

    task automatic wait_fetch1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy && write_en == M_AR && bus_ld == 4'd2) begin ok = 1'b1; return; end
        end
    endtask

    initial begin
        bit ok;
        instr_t in;
        int n;
        repeat (3) @(negedge clk);
        chk("reset_word", observed(), 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_release", busy, 0);

        prog.push_back('{1, 0, 0, 3});
        prog.push_back('{10, 4, 0, 0});
        prog.push_back('{10, 6, 0, 1});
        prog.push_back('{15, 0, 0, 2});
        prog.push_back('{15, 0, 1, 0});
        prog.push_back('{4, 0, 0, 1});
        prog.push_back('{16, 1, 1, 0});
        prog.push_back('{16, 1, 0, 0});
        prog.push_back('{5, 2, 0, 0});
        prog.push_back('{6, 4, 0, 0});
        prog.push_back('{7, 5, 0, 0});
        prog.push_back('{11, 0, 0, 0});
        prog.push_back('{12, 0, 0, 0});
        prog.push_back('{13, 0, 0, 0});
        prog.push_back('{14, 0, 0, 0});
        prog.push_back('{0, 0, 0, 0});
        prog.push_back('{20, 0, 0, 0});
        prog.push_back('{2, 0, 0, 2});
        prog.push_back('{3, 0, 0, 1});
        for (int i = 0; i < 40; i++) begin
            in.op = int'($urandom_range(0, 30));
            if (in.op >= 17) in.op++;
            in.idx  = int'($urandom_range(0, 7));
            in.zz   = 1'($urandom_range(0, 1));
            in.want = int'($urandom_range(0, 2));
            prog.push_back(in);
        end
        prog.push_back('{17, 0, 0, 0});
        n = prog.size();

        expq.push_back(st(0, 0, 0, 0, 0, 7, 0, 0, 0));
        push_instr(prog[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            wait_fetch1(ok);
            if (!ok) begin
                chk("fetch1_timeout", 0, 1);
                break;
            end
            ir   = {prog[k].op[4:0], prog[k].idx[2:0]};
            z    = prog[k].zz;
            want = prog[k].want;
            if (k + 1 < n) push_instr(prog[k + 1]);
        end

        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = end_op;
        end
        chk("end_op_seen", ok, 1);
        @(negedge clk);
        chk("end_op_single", end_op, 0);
        chk("busy_falls", busy, 0);
        chk("queue_drained", expq.size(), 0);
        chk("im_wr_zero", im_wr, 0);

        want = 3;
        expq.push_back(st(0, 0, 0, 0, 0, 7, 0, 0, 0));
        expq.push_back(st(0, M_AR, 2, 0, 0, 0, 0, 0, 0));
        expq.push_back(st(1, M_DR, 0, 1, 0, 0, 0, 0, 0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = mem_req;
        end
        chk("fetch2_reached", ok, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_word", observed(), 0);
        chk("async_reset_busy", busy, 0);
        expq.delete();
        run = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
